// File: rtl/bitset_build_if.sv
// Stream bundle for bitset_build: the index-beat input channel and the assembled-word output channel.
interface bitset_build_if #(
  parameter int ORDER = 3
);
  localparam int W = 2 ** ORDER;

  logic             in_valid;
  logic             in_ready;
  logic [ORDER-1:0] in_index;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [W-1:0]     out_word;
  logic [ORDER:0]   out_count;
  logic             out_dup;

  modport master (
    output in_valid, in_index, in_last, out_ready,
    input  in_ready, out_valid, out_word, out_count, out_dup
  );

  modport slave (
    input  in_valid, in_index, in_last, out_ready,
    output in_ready, out_valid, out_word, out_count, out_dup
  );
endinterface

// File: rtl/bitset_build.sv
// Assembles a frame of index beats into a W-bit set with a distinct-bit count; result one cycle after the last beat.
// Input stalls only while a result is held unconsumed. Optional duplicate flag: BITSET_BUILD_DUP_DETECT_EN.
module bitset_build #(
  parameter int ORDER = 3
) (
  input  logic          clock,
  input  logic          reset_n,
  bitset_build_if.slave bus
);
  localparam int W = 2 ** ORDER;

  logic [W-1:0]   r_acc;
  logic [ORDER:0] r_acc_count;
  logic [W-1:0]   r_word;
  logic [ORDER:0] r_count;
  logic           r_out_valid;

  logic           w_in_ready;
  logic           w_in_fire;
  logic           w_out_fire;
  logic           w_bit_seen;
  logic [W-1:0]   w_onehot;
  logic [W-1:0]   w_acc_next;
  logic [ORDER:0] w_count_next;

  assign w_in_ready   = !r_out_valid || bus.out_ready;
  assign w_in_fire    = bus.in_valid && w_in_ready;
  assign w_out_fire   = r_out_valid && bus.out_ready;
  assign w_bit_seen   = r_acc[bus.in_index];
  assign w_onehot     = {{(W-1){1'b0}}, 1'b1} << bus.in_index;
  assign w_acc_next   = r_acc | w_onehot;
  // A repeated index sets nothing new, so it must not bump the count.
  assign w_count_next = r_acc_count + {{ORDER{1'b0}}, ~w_bit_seen};

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_acc       <= '0;
      r_acc_count <= '0;
      r_word      <= '0;
      r_count     <= '0;
      r_out_valid <= 1'b0;
    end else begin
      if (w_out_fire) begin
        r_out_valid <= 1'b0;
      end
      if (w_in_fire) begin
        if (bus.in_last) begin
          r_word      <= w_acc_next;
          r_count     <= w_count_next;
          r_out_valid <= 1'b1;
          r_acc       <= '0;
          r_acc_count <= '0;
        end else begin
          r_acc       <= w_acc_next;
          r_acc_count <= w_count_next;
        end
      end
    end
  end

`ifdef BITSET_BUILD_DUP_DETECT_EN
  logic r_dup_flag;
  logic r_dup;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_dup_flag <= 1'b0;
      r_dup      <= 1'b0;
    end else if (w_in_fire) begin
      if (bus.in_last) begin
        r_dup      <= r_dup_flag | w_bit_seen;
        r_dup_flag <= 1'b0;
      end else if (w_bit_seen) begin
        r_dup_flag <= 1'b1;
      end
    end
  end

  assign bus.out_dup = r_dup;
`else
  assign bus.out_dup = 1'b0;
`endif

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.out_word  = r_word;
  assign bus.out_count = r_count;
endmodule

// File: tb/tb_bitset_build.sv
// Directed and randomized checks of bitset_build against a frame-list reference model.
module tb_bitset_build;
  localparam int ORDER = 3;
  localparam int W     = 2 ** ORDER;

  logic clock   = 1'b0;
  logic reset_n = 1'b0;

  bitset_build_if #(.ORDER(ORDER)) bus ();

  bitset_build #(.ORDER(ORDER)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: the frame is kept as a plain list of indices.
  int             m_frame[$];
  logic           m_ov;
  logic [W-1:0]   m_word;
  logic [ORDER:0] m_count;
  logic           m_dup;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_frame.delete();
    m_ov    = 1'b0;
    m_word  = '0;
    m_count = '0;
    m_dup   = 1'b0;
  endtask

  task automatic close_frame();
    logic [W-1:0] word;
    logic         dup;
    word = '0;
    dup  = 1'b0;
    foreach (m_frame[k]) begin
      if (word[m_frame[k]]) dup = 1'b1;
      word[m_frame[k]] = 1'b1;
    end
    m_word  = word;
    m_count = ($countones(word)) & ((1 << (ORDER + 1)) - 1);
`ifdef BITSET_BUILD_DUP_DETECT_EN
    m_dup   = dup;
`else
    m_dup   = 1'b0;
`endif
    m_ov    = 1'b1;
    m_frame.delete();
  endtask

  // Called just after a rising edge; returns just after the next one.
  task automatic step(input logic v, input int idx, input logic last, input logic ordy);
    logic exp_rdy;
    bus.in_valid  = v;
    bus.in_index  = idx[ORDER-1:0];
    bus.in_last   = last;
    bus.out_ready = ordy;
    @(negedge clock);
    exp_rdy = !m_ov || ordy;
    check("in_ready", {31'b0, bus.in_ready}, {31'b0, exp_rdy});
    check("out_valid", {31'b0, bus.out_valid}, {31'b0, m_ov});
    check("out_word", 32'(bus.out_word), 32'(m_word));
    check("out_count", 32'(bus.out_count), 32'(m_count));
    if (m_ov) check("out_dup", {31'b0, bus.out_dup}, {31'b0, m_dup});
    if (m_ov && ordy) m_ov = 1'b0;
    if (v && exp_rdy) begin
      m_frame.push_back(idx);
      if (last) close_frame();
    end
    @(posedge clock);
    #1;
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_ov"}, {31'b0, bus.out_valid}, 32'd0);
    check({tag, "_word"}, 32'(bus.out_word), 32'd0);
    check({tag, "_count"}, 32'(bus.out_count), 32'd0);
    check({tag, "_dup"}, {31'b0, bus.out_dup}, 32'd0);
    check({tag, "_rdy"}, {31'b0, bus.in_ready}, 32'd1);
  endtask

  logic exp_dup_rep;

  initial begin
`ifdef BITSET_BUILD_DUP_DETECT_EN
    exp_dup_rep = 1'b1;
`else
    exp_dup_rep = 1'b0;
`endif
    bus.in_valid  = 1'b0;
    bus.in_index  = '0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b1;
    model_reset();
    #1;
    check_zero_outputs("reset");
    @(posedge clock);
    @(posedge clock);
    #1;
    reset_n = 1'b1;

    // Beats 1, 4, 6(last)
    step(1'b1, 1, 1'b0, 1'b1);
    step(1'b1, 4, 1'b0, 1'b1);
    step(1'b1, 6, 1'b1, 1'b1);
    check("basic_ov", {31'b0, bus.out_valid}, 32'd1);
    check("basic_word", 32'(bus.out_word), 32'h52);
    check("basic_count", 32'(bus.out_count), 32'd3);
    check("basic_dup", {31'b0, bus.out_dup}, 32'd0);

    // Repeated index
    step(1'b1, 2, 1'b0, 1'b1);
    step(1'b1, 2, 1'b0, 1'b1);
    step(1'b1, 2, 1'b1, 1'b1);
    check("rep_word", 32'(bus.out_word), 32'h04);
    check("rep_count", 32'(bus.out_count), 32'd1);
    check("rep_dup", {31'b0, bus.out_dup}, {31'b0, exp_dup_rep});

    // Single-beat frames back to back at full throughput
    for (int i = 0; i < W; i++) begin
      step(1'b1, i, 1'b1, 1'b1);
      check("stream_ov", {31'b0, bus.out_valid}, 32'd1);
      check("stream_word", 32'(bus.out_word), 32'(1 << i));
      check("stream_count", 32'(bus.out_count), 32'd1);
    end

    // Full frame, then hold under backpressure
    for (int i = 0; i < W; i++) step(1'b1, i, (i == W - 1), 1'b1);
    for (int c = 0; c < 3; c++) begin
      step(1'b1, 3, 1'b1, 1'b0);
      check("hold_word", 32'(bus.out_word), 32'hFF);
      check("hold_count", 32'(bus.out_count), 32'd8);
      check("hold_rdy", {31'b0, bus.in_ready}, 32'd0);
    end
    step(1'b1, 3, 1'b1, 1'b1);
    check("release_word", 32'(bus.out_word), 32'h08);
    check("release_count", 32'(bus.out_count), 32'd1);

    // Reset in the middle of a frame
    step(1'b1, 3, 1'b0, 1'b1);
    step(1'b1, 5, 1'b0, 1'b1);
    bus.in_valid = 1'b0;
    reset_n = 1'b0;
    #1;
    check_zero_outputs("midreset");
    model_reset();
    @(posedge clock);
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    step(1'b1, 0, 1'b1, 1'b1);
    check("postrst_word", 32'(bus.out_word), 32'h01);
    check("postrst_count", 32'(bus.out_count), 32'd1);

    // Randomized traffic
    for (int n = 0; n < 600; n++) begin
      step(($urandom_range(0, 3) != 0), int'($urandom_range(0, W - 1)),
           ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) != 0));
    end
    for (int n = 0; n < 4; n++) step(1'b0, 0, 1'b0, 1'b1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule

// File: doc/bitset_build.md
BITSET_BUILD -- requirements
Module: bitset_build

Interface
REQ-001 Parameter: ORDER, default 3, log2 of word width; W = 2**ORDER.
REQ-002 Port: clock  input  1  single clock; all state updates on rising edge.
REQ-003 Port: reset_n  input  1  asynchronous, active-low reset.
REQ-004 Port: in_valid  input  1  input beat present.
REQ-005 Port: in_ready  output  1  block accepts the input beat this cycle.
REQ-006 Port: in_index  input  ORDER  bit position to set in the word under assembly.
REQ-007 Port: in_last  input  1  beat closes the current frame.
REQ-008 Port: out_valid  output  1  assembled word available.
REQ-009 Port: out_ready  input  1  consumer takes the word this cycle.
REQ-010 Port: out_word  output  W  assembled bit set.
REQ-011 Port: out_count  output  ORDER+1  number of distinct bits set in out_word (0..W).
REQ-012 Port: out_dup  output  1  frame contained a repeated index (see Configuration).

Function
REQ-013 Input transfer: in_valid && in_ready at a rising edge; output transfer: out_valid && out_ready at a rising edge.
REQ-014 in_ready SHALL be !out_valid || out_ready (combinational, no other stall source).
REQ-015 Accepted non-last beat: acc[in_index] <= 1; acc_count increments only if acc[in_index] was 0.
REQ-016 Accepted last beat: out_word <= acc | (1 << in_index), out_count <= acc_count + (acc[in_index] ? 0 : 1), out_valid <= 1; acc and acc_count cleared to 0 in the same edge.
REQ-017 Latency: out_valid asserts the cycle after the accepting edge of the last beat.
REQ-018 Output transfer without a simultaneous last-beat transfer: out_valid <= 0; out_word/out_count hold their value.
REQ-019 Output transfer and last-beat transfer on the same edge: new frame is loaded and out_valid stays 1 (full throughput, one frame per cycle for single-beat frames).
REQ-020 While out_valid && !out_ready: out_word, out_count, out_dup stable; no input accepted.
REQ-021 A frame always has at least one beat; out_count is never 0 while out_valid is 1.
REQ-022 Frame of W distinct indices: out_word all ones, out_count = W (no wrap; count width ORDER+1).
REQ-023 in_index, in_last are ignored when no input transfer occurs.

Reset
REQ-024 reset_n low SHALL, without a clock edge, force out_valid=0, out_word=0, out_count=0, out_dup=0, acc=0, acc_count=0, dup flag=0.
REQ-025 Reset mid-frame discards the partial frame; the first accepted beat after reset release starts a new frame.
REQ-026 in_ready is 1 while in reset (follows from out_valid=0).

Configuration
REQ-027 Macro BITSET_BUILD_DUP_DETECT_EN, when defined: a sticky frame flag sets on any accepted beat whose index is already in acc; out_dup <= flag | (last-beat duplicate) on frame close; flag cleared with acc.
REQ-028 Without BITSET_BUILD_DUP_DETECT_EN: out_dup is constant 0, no flag register; all other behaviour identical (duplicates still do not increment counts).

Verification
REQ-029 ORDER=3, out_ready=1: beats 1, 4, 6(last) -> one cycle later out_valid=1, out_word=0x52, out_count=3, out_dup=0.
REQ-030 Beats 2, 2, 2(last) -> out_word=0x04, out_count=1, out_dup=1 with macro, 0 without.
REQ-031 Single-beat frames 0,1,...,7 back-to-back, out_ready=1 -> in_ready constantly 1, out_valid constantly 1 from cycle 2, out_word 0x01,0x02,...,0x80, out_count=1 each.
REQ-032 Frame 0..7 (last on 7), out_ready=0 for 3 cycles after -> out_word=0xFF, out_count=8 held stable, in_ready=0 for those 3 cycles, beat presented meanwhile not accepted; out_ready=1 then releases and accepts it.
REQ-033 Beats 3, 5 then reset_n low for 2 cycles, then beat 0(last) -> out_word=0x01, out_count=1; outputs 0 asynchronously during reset.
